// File: rtl/ps2_xt_scan_bridge.sv
// PS/2 set-2 receiver -> set-1 translator -> FIFO -> XT serialiser; push lands 1 cycle after the stop-bit edge.
// No backpressure from the PC: a push into a full FIFO without a same-cycle pop is dropped and flags OVERRUN.
module ps2_xt_scan_bridge #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CLK_DIV     = 500,
    parameter int TIMEOUT     = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    input  logic                          XLAT_EN,
    input  logic                          HOST_RESET_N,
    input  logic                          OVERRUN_CLR,
    output logic                          XT_CLK,
    output logic                          XT_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERRUN,
    output logic                          PARITY_ERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] XLAT_LO [128] = '{
        8'hff, 8'h43, 8'h41, 8'h3f, 8'h3d, 8'h3b, 8'h3c, 8'h58, 8'h64, 8'h44, 8'h42, 8'h40, 8'h3e, 8'h0f, 8'h29, 8'h59,
        8'h65, 8'h38, 8'h2a, 8'h70, 8'h1d, 8'h10, 8'h02, 8'h5a, 8'h66, 8'h71, 8'h2c, 8'h1f, 8'h1e, 8'h11, 8'h03, 8'h5b,
        8'h67, 8'h2e, 8'h2d, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5c, 8'h68, 8'h39, 8'h2f, 8'h21, 8'h14, 8'h13, 8'h06, 8'h5d,
        8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5e, 8'h6a, 8'h72, 8'h32, 8'h24, 8'h16, 8'h08, 8'h09, 8'h5f,
        8'h6b, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0b, 8'h0a, 8'h60, 8'h6c, 8'h34, 8'h35, 8'h26, 8'h27, 8'h19, 8'h0c, 8'h61,
        8'h6d, 8'h73, 8'h28, 8'h74, 8'h1a, 8'h0d, 8'h62, 8'h6e, 8'h3a, 8'h36, 8'h1c, 8'h1b, 8'h75, 8'h2b, 8'h63, 8'h76,
        8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h0e, 8'h7b, 8'h7c, 8'h4f, 8'h7d, 8'h4b, 8'h47, 8'h7e, 8'h7f, 8'h6f,
        8'h52, 8'h53, 8'h50, 8'h4c, 8'h4d, 8'h48, 8'h01, 8'h45, 8'h57, 8'h4e, 8'h51, 8'h4a, 8'h37, 8'h49, 8'h46, 8'h54
    };

    function automatic logic [7:0] xlat(input logic [7:0] b);
        if (!b[7])             return XLAT_LO[b[6:0]];
        else if (b == 8'h83)   return 8'h41;
        else if (b == 8'h84)   return 8'h54;
        else                   return b;
    endfunction

    typedef enum logic [3:0] {
        T_IDLE, T_START, T_BIT0, T_BIT1, T_BIT2, T_BIT3,
        T_BIT4, T_BIT5, T_BIT6, T_BIT7, T_GAP
    } tx_state_e;

    logic [SYNC_STAGES-1:0] ps2c_sync_q, ps2c_sync_d, ps2d_sync_q, ps2d_sync_d;
    logic                   ps2c_prev_q, ps2c_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             rx_sr_q, rx_sr_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   rx_vld_q, rx_vld_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic                   perr_q, perr_d;
    logic                   hr_q, hr_d;
    logic                   brk_q, brk_d;
    logic                   ovr_q, ovr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    tx_state_e              state_q, state_d;
    logic [DW-1:0]          div_q, div_d;
    logic [7:0]             sh_q, sh_d;
    logic                   xt_clk_q, xt_clk_d, xt_dat_q, xt_dat_d;

    logic       ps2c_s, ps2d_s, ps2_fall;
    logic       push, do_push, pop, full, bat;
    logic [7:0] push_dat;
    logic [2:0] bit_idx;

    assign ps2c_s   = ps2c_sync_q[SYNC_STAGES-1];
    assign ps2d_s   = ps2d_sync_q[SYNC_STAGES-1];
    assign ps2_fall = ps2c_prev_q & ~ps2c_s;

    always_comb begin
        ps2c_sync_d = {ps2c_sync_q[SYNC_STAGES-2:0], PS2_CLK};
        ps2d_sync_d = {ps2d_sync_q[SYNC_STAGES-2:0], PS2_DATA};
        ps2c_prev_d = ps2c_s;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        to_cnt_d    = to_cnt_q;
        rx_vld_d    = 1'b0;
        rx_byte_d   = rx_byte_q;
        perr_d      = 1'b0;
        if (ps2_fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                // rx_sr holds start[0], D0..D7[8:1], parity[9]; the stop bit is on the line now
                if (!rx_sr_q[0] && ps2d_s && (^rx_sr_q[9:1])) begin
                    rx_vld_d  = 1'b1;
                    rx_byte_d = rx_sr_q[8:1];
                end else begin
                    perr_d = 1'b1;
                end
            end else begin
                rx_sr_d   = {ps2d_s, rx_sr_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    always_comb begin
        hr_d     = HOST_RESET_N;
        bat      = HOST_RESET_N & ~hr_q;
        push     = 1'b0;
        push_dat = 8'h00;
        brk_d    = brk_q;
        if (!HOST_RESET_N) begin
            brk_d = 1'b0;
        end else if (bat) begin
            push     = 1'b1;
            push_dat = 8'hAA;
        end else if (rx_vld_q) begin
            if (!XLAT_EN) begin
                push     = 1'b1;
                push_dat = rx_byte_q;
            end else if (rx_byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rx_byte_q == 8'hE0) begin
                push     = 1'b1;
                push_dat = 8'hE0;
            end else begin
                push     = 1'b1;
                push_dat = xlat(rx_byte_q) | {brk_q, 7'b0};
                brk_d    = 1'b0;
            end
        end
        if (!XLAT_EN) brk_d = 1'b0;

        pop     = 1'b0;
        state_d = state_q;
        div_d   = div_q;
        sh_d    = sh_q;
        if (!HOST_RESET_N) begin
            state_d = T_IDLE;
            div_d   = '0;
        end else if (state_q == T_IDLE) begin
            if (cnt_q != '0) begin
                pop     = 1'b1;
                sh_d    = mem_q[rd_ptr_q];
                state_d = T_START;
                div_d   = '0;
            end
        end else if (div_q == DW'(2 * CLK_DIV - 1)) begin
            div_d   = '0;
            state_d = (state_q == T_GAP) ? T_IDLE : tx_state_e'(state_q + 4'd1);
        end else begin
            div_d = div_q + DW'(1);
        end

        // Outputs follow the next state, so XT_DATA moves only as a new high phase begins
        bit_idx  = 3'(4'(state_d) - 4'(T_BIT0));
        xt_clk_d = 1'b1;
        xt_dat_d = 1'b1;
        if (state_d inside {[T_START:T_BIT7]}) xt_clk_d = (div_d < DW'(CLK_DIV));
        if (state_d inside {[T_BIT0:T_BIT7]})  xt_dat_d = sh_d[bit_idx];

        full    = (cnt_q == CW'(FIFO_DEPTH));
        do_push = push & (~full | pop);
        ovr_d   = ovr_q;
        if (OVERRUN_CLR) ovr_d = 1'b0;
        if (push && full && !pop) ovr_d = 1'b1;
        if (!HOST_RESET_N) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            cnt_d    = cnt_q + CW'(do_push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ps2c_sync_q <= '1;
            ps2d_sync_q <= '1;
            ps2c_prev_q <= 1'b1;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            to_cnt_q    <= '0;
            rx_vld_q    <= 1'b0;
            rx_byte_q   <= '0;
            perr_q      <= 1'b0;
            hr_q        <= 1'b1;
            brk_q       <= 1'b0;
            ovr_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            state_q     <= T_IDLE;
            div_q       <= '0;
            sh_q        <= '0;
            xt_clk_q    <= 1'b1;
            xt_dat_q    <= 1'b1;
        end else begin
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
            ps2c_prev_q <= ps2c_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            to_cnt_q    <= to_cnt_d;
            rx_vld_q    <= rx_vld_d;
            rx_byte_q   <= rx_byte_d;
            perr_q      <= perr_d;
            hr_q        <= hr_d;
            brk_q       <= brk_d;
            ovr_q       <= ovr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            div_q       <= div_d;
            sh_q        <= sh_d;
            xt_clk_q    <= xt_clk_d;
            xt_dat_q    <= xt_dat_d;
        end
    end

    assign XT_CLK     = xt_clk_q;
    assign XT_DATA    = xt_dat_q;
    assign FIFO_COUNT = cnt_q;
    assign OVERRUN    = ovr_q;
    assign PARITY_ERR = perr_q;
endmodule

// File: tb/tb_ps2_xt_scan_bridge.sv
// Directed bench for ps2_xt_scan_bridge: drives PS/2 frames, decodes the XT line and scoreboards bytes.
module tb_ps2_xt_scan_bridge;
    localparam int FIFO_DEPTH = 8;
    localparam int CLK_DIV    = 60;
    localparam int TIMEOUT    = 200;
    localparam int HALF       = 4;

    logic       clk, rst_n, ps2_clk, ps2_data, xlat_en, host_reset_n, overrun_clr;
    logic       xt_clk, xt_data, overrun, parity_err;
    logic [3:0] fifo_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         perr_cnt = 0;
    int         nz_cnt   = 0;
    int         mon_bits = 0;
    logic [7:0] exp_q [$];

    ps2_xt_scan_bridge #(
        .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .XLAT_EN(xlat_en), .HOST_RESET_N(host_reset_n), .OVERRUN_CLR(overrun_clr),
        .XT_CLK(xt_clk), .XT_DATA(xt_data), .FIFO_COUNT(fifo_count),
        .OVERRUN(overrun), .PARITY_ERR(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // XT line decoder: samples XT_DATA on each falling XT_CLK; a long high phase restarts the frame
    initial begin
        logic       prev_clk;
        logic       st;
        logic [7:0] sh;
        int         hi_cnt;
        prev_clk = 1'b1; st = 1'b0; sh = '0; hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_bits = 0;
                hi_cnt   = 0;
            end else begin
                if (prev_clk && !xt_clk) begin
                    if (mon_bits == 0) st = xt_data;
                    else               sh = {xt_data, sh[7:1]};
                    mon_bits++;
                    if (mon_bits == 9) begin
                        mon_bits = 0;
                        check("xt_start_bit", st, 1);
                        n_checks++;
                        assert (exp_q.size() != 0) else begin
                            n_fail++;
                            $error("FAIL xt_unexpected_byte observed=%02h expected=none", sh);
                        end
                        if (exp_q.size() != 0) check("xt_byte", sh, exp_q.pop_front());
                    end
                end
                hi_cnt = xt_clk ? hi_cnt + 1 : 0;
                if (hi_cnt > CLK_DIV + 3) mon_bits = 0;
            end
            prev_clk = xt_clk;
            if (parity_err) perr_cnt++;
            if (fifo_count != 0) nz_cnt++;
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3 * CLK_DIV) @(negedge clk);
        check(tag, exp_q.size(), 0);
        check({tag, "_xt_clk_idle"}, xt_clk, 1);
    endtask

    task automatic wait_bits(input int nb, input string tag);
        int n;
        n = 0;
        while (mon_bits != nb && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, mon_bits, nb);
    endtask

    initial begin
        logic [7:0] codes [10];
        logic [7:0] xt    [10];
        int p0, z0, lows;
        codes = '{8'h1C, 8'h5A, 8'h76, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
        xt    = '{8'h1E, 8'h1C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; xlat_en = 1'b1;
        host_reset_n = 1'b1; overrun_clr = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_xt_clk", xt_clk, 1);
        check("rst_xt_data", xt_data, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: single make code, FIFO occupancy is a one-cycle blip
        z0 = nz_cnt;
        exp_q.push_back(8'h1E);
        send_frame(8'h1C, 1'b0);
        repeat (5) @(negedge clk);
        check("t1_fifo_pulse_cycles", nz_cnt - z0, 1);
        wait_drain("t1_drain");

        // 2: break folding with translation, raw pass-through without
        exp_q.push_back(8'h9E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        wait_drain("t2a_drain");
        xlat_en = 1'b0;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        wait_drain("t2b_drain");
        xlat_en = 1'b1;

        // 3: bad parity is flagged for exactly one cycle and never queued
        p0 = perr_cnt; z0 = nz_cnt;
        send_frame(8'h1C, 1'b1);
        repeat (10) @(negedge clk);
        check("t3_perr_cycles", perr_cnt - p0, 1);
        check("t3_fifo_untouched", nz_cnt - z0, 0);
        check("t3_xt_data_idle", xt_data, 1);
        wait_drain("t3_drain");

        // 4: ten frames back-to-back: one in flight, eight queued, one dropped
        for (int i = 0; i < 9; i++) exp_q.push_back(xt[i]);
        for (int i = 0; i < 10; i++) send_frame(codes[i], 1'b0);
        check("t4_fifo_full", fifo_count, FIFO_DEPTH);
        check("t4_overrun_set", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        @(negedge clk);
        check("t4_overrun_cleared", overrun, 0);
        wait_drain("t4_drain");

        // 5: host reset during bit 3 with three bytes queued, then BAT
        for (int i = 0; i < 4; i++) exp_q.push_back(xt[i]);
        for (int i = 0; i < 4; i++) send_frame(codes[i], 1'b0);
        check("t5_fifo_queued", fifo_count, 3);
        wait_bits(4, "t5_reached_bit2");
        repeat (2 * CLK_DIV + 10) @(negedge clk);
        check("t5_bit3_low_phase", xt_clk, 0);
        host_reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t5_hrst_xt_clk", xt_clk, 1);
        check("t5_hrst_xt_data", xt_data, 1);
        check("t5_hrst_fifo_flushed", fifo_count, 0);
        repeat (9) @(negedge clk);
        check("t5_hrst_fifo_still_empty", fifo_count, 0);
        exp_q.push_back(8'hAA);
        host_reset_n = 1'b1;
        wait_drain("t5_bat_drain");

        // 6: abandoned partial frame is discarded silently after the timeout
        p0 = perr_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 10) @(negedge clk);
        exp_q.push_back(8'h01);
        send_frame(8'h76, 1'b0);
        wait_drain("t6_drain");
        check("t6_no_perr", perr_cnt - p0, 0);

        // 7: system reset mid-transmit returns to idle without emitting the rest
        exp_q.push_back(8'h1E);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h5A, 1'b0);
        wait_bits(3, "t7_mid_byte");
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t7_rst_xt_clk", xt_clk, 1);
        check("t7_rst_xt_data", xt_data, 1);
        check("t7_rst_fifo_count", fifo_count, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!xt_clk) lows++;
        end
        check("t7_line_quiet_after_reset", lows, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
